// File: rtl/cordic_pkg.sv
// Shared CORDIC constants, operand layout and command-deframer state encoding.
package cordic_pkg;

  localparam int CORDIC_XY_W         = 10;
  localparam int CORDIC_PH_W         = 14;
  localparam int FRAME_PAYLOAD_BYTES = 4;
  localparam int PAYLOAD_W           = 8 * FRAME_PAYLOAD_BYTES;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_e;

  typedef struct packed {
    logic [CORDIC_XY_W-1:0] x;
    logic [CORDIC_XY_W-1:0] y;
    logic [CORDIC_PH_W-1:0] phase;
  } operand_t;

  localparam int OPERAND_W = $bits(operand_t);

  // Phase carries 12 payload bits left-justified in a 14-bit angle word.
  function automatic operand_t unpack_payload(input logic [PAYLOAD_W-1:0] w);
    operand_t op;
    op.x     = w[31:22];
    op.y     = w[21:12];
    op.phase = {w[11:0], 2'b00};
    return op;
  endfunction

endpackage

// File: rtl/cordic_operand_hold.sv
// One-deep valid/ready holding register; loads on in_vld when empty or draining this cycle.
// Latency 1 cycle; a load attempted while full and stalled is dropped and flagged by a one-cycle overrun.
module cordic_operand_hold #(
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  input  logic         out_rdy,
  output logic         out_vld,
  output logic [W-1:0] out_dat,
  output logic         overrun
);

  logic accept;

  assign accept = in_vld && (!out_vld || out_rdy);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_vld <= 1'b0;
      out_dat <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= in_vld && out_vld && !out_rdy;
      if (accept) begin
        out_vld <= 1'b1;
        out_dat <= in_dat;
      end else if (out_rdy) begin
        out_vld <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cordic_cmd_deframer.sv
// Sync-hunting deframer: SYNC,P0..P3,CK bytes -> x/y/phase operand with XOR check and inter-byte timeout.
// o_valid rises 1 cycle after a good CK; held until i_ready; a good frame arriving while stalled is dropped (o_overrun).
module cordic_cmd_deframer
  import cordic_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_rx_dv,
  input  logic [7:0]             i_rx_byte,
  input  logic                   i_ready,
  output logic                   o_valid,
  output logic [CORDIC_XY_W-1:0] o_xcord,
  output logic [CORDIC_XY_W-1:0] o_ycord,
  output logic [CORDIC_PH_W-1:0] o_phase,
  output logic                   o_crc_err,
  output logic                   o_timeout_err,
  output logic                   o_overrun
);

  localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  state_e                 state_q, state_d;
  logic [1:0]             idx_q, idx_d;
  logic [PAYLOAD_W-1:0]   word_q, word_d;
  logic [7:0]             xor_q, xor_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   crc_err_d, tmo_err_d;
  logic                   timeout_hit;
  logic                   load_vld;
  operand_t               load_dat, hold_dat;

  // A byte arriving on the limit cycle takes priority over the timeout.
  assign timeout_hit = (state_q != IDLE) && !i_rx_dv && (cnt_q == CNT_MAX);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    word_d    = word_q;
    xor_d     = xor_q;
    cnt_d     = cnt_q;
    crc_err_d = 1'b0;
    tmo_err_d = 1'b0;
    load_vld  = 1'b0;

    if (state_q == IDLE || i_rx_dv) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (i_rx_dv && i_rx_byte == SYNC_BYTE) begin
          state_d = PAYLOAD;
          idx_d   = 2'd0;
          xor_d   = 8'h00;
        end
      end
      PAYLOAD: begin
        if (i_rx_dv) begin
          word_d = {word_q[PAYLOAD_W-9:0], i_rx_byte};
          xor_d  = xor_q ^ i_rx_byte;
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'(FRAME_PAYLOAD_BYTES - 1)) begin
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        if (i_rx_dv) begin
          state_d = IDLE;
          if (i_rx_byte != xor_q) begin
            crc_err_d = 1'b1;
          end else begin
            load_vld = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (timeout_hit) begin
      state_d   = IDLE;
      tmo_err_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= IDLE;
      idx_q         <= 2'd0;
      word_q        <= '0;
      xor_q         <= 8'h00;
      cnt_q         <= '0;
      o_crc_err     <= 1'b0;
      o_timeout_err <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      word_q        <= word_d;
      xor_q         <= xor_d;
      cnt_q         <= cnt_d;
      o_crc_err     <= crc_err_d;
      o_timeout_err <= tmo_err_d;
    end
  end

  assign load_dat = unpack_payload(word_q);

  cordic_operand_hold #(
    .W (OPERAND_W)
  ) u_hold (
    .clk     (i_clk),
    .reset   (i_reset),
    .in_vld  (load_vld),
    .in_dat  (load_dat),
    .out_rdy (i_ready),
    .out_vld (o_valid),
    .out_dat (hold_dat),
    .overrun (o_overrun)
  );

  assign o_xcord = hold_dat.x;
  assign o_ycord = hold_dat.y;
  assign o_phase = hold_dat.phase;

endmodule

// File: tb/tb_cordic_cmd_deframer.sv
// Scoreboard bench for cordic_cmd_deframer: expected operands queued at stimulus, popped on each handshake.
module tb_cordic_cmd_deframer;

  localparam int T = 20;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_rx_dv = 1'b0;
  logic [7:0]  i_rx_byte = 8'h00;
  logic        i_ready = 1'b1;
  logic        o_valid;
  logic [9:0]  o_xcord;
  logic [9:0]  o_ycord;
  logic [13:0] o_phase;
  logic        o_crc_err;
  logic        o_timeout_err;
  logic        o_overrun;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [13:0] ph;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   crc_cnt = 0;
  int   tmo_cnt = 0;
  int   ovr_cnt = 0;
  logic prev_crc = 1'b0, prev_tmo = 1'b0, prev_ovr = 1'b0;
  logic prev_hold = 1'b0;
  exp_t prev_dat;

  always #5 clk = ~clk;

  cordic_cmd_deframer #(
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_rx_dv       (i_rx_dv),
    .i_rx_byte     (i_rx_byte),
    .i_ready       (i_ready),
    .o_valid       (o_valid),
    .o_xcord       (o_xcord),
    .o_ycord       (o_ycord),
    .o_phase       (o_phase),
    .o_crc_err     (o_crc_err),
    .o_timeout_err (o_timeout_err),
    .o_overrun     (o_overrun)
  );

  function automatic exp_t model(input logic [7:0] p0, p1, p2, p3);
    logic [31:0] w;
    exp_t e;
    w    = {p0, p1, p2, p3};
    e.x  = w[31:22];
    e.y  = w[21:12];
    e.ph = {w[11:0], 2'b00};
    return e;
  endfunction

  // Monitor: handshakes drain the scoreboard; pulses are counted and must be single-cycle.
  always @(negedge clk) begin
    if (i_reset) begin
      prev_crc  = 1'b0;
      prev_tmo  = 1'b0;
      prev_ovr  = 1'b0;
      prev_hold = 1'b0;
    end else begin
      if (prev_hold && o_valid) begin
        checks++;
        if ({o_xcord, o_ycord, o_phase} !== prev_dat) begin
          errors++;
          $display("FAIL hold_stable: got %h want %h", {o_xcord, o_ycord, o_phase}, prev_dat);
        end
      end
      if (o_valid && i_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got x=%h y=%h ph=%h want no output", o_xcord, o_ycord, o_phase);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if ({o_xcord, o_ycord, o_phase} !== e) begin
            errors++;
            $display("FAIL sb_operand: got x=%h y=%h ph=%h want x=%h y=%h ph=%h",
                     o_xcord, o_ycord, o_phase, e.x, e.y, e.ph);
          end
        end
      end
      if (o_crc_err) begin
        crc_cnt++;
        checks++;
        if (prev_crc !== 1'b0) begin errors++; $display("FAIL crc_width: got 2+ cycles want 1"); end
      end
      if (o_timeout_err) begin
        tmo_cnt++;
        checks++;
        if (prev_tmo !== 1'b0) begin errors++; $display("FAIL tmo_width: got 2+ cycles want 1"); end
      end
      if (o_overrun) begin
        ovr_cnt++;
        checks++;
        if (prev_ovr !== 1'b0) begin errors++; $display("FAIL ovr_width: got 2+ cycles want 1"); end
      end
      prev_crc  = o_crc_err;
      prev_tmo  = o_timeout_err;
      prev_ovr  = o_overrun;
      prev_hold = o_valid && !i_ready;
      prev_dat  = {o_xcord, o_ycord, o_phase};
    end
  end

  task automatic send_byte(input logic [7:0] b);
    i_rx_dv   = 1'b1;
    i_rx_byte = b;
    @(posedge clk); #1;
    i_rx_dv   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] p0, p1, p2, p3, ck);
    send_byte(8'hA5);
    send_byte(p0);
    send_byte(p1);
    send_byte(p2);
    send_byte(p3);
    send_byte(ck);
  endtask

  task automatic test_reset;
    i_reset = 1'b1;
    idle(3);
    i_reset = 1'b0;
    checks++;
    if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    checks++;
    if ({o_xcord, o_ycord, o_phase} !== 34'd0) begin
      errors++; $display("FAIL reset_operand: got %h want 0", {o_xcord, o_ycord, o_phase});
    end
    checks++;
    if ({o_crc_err, o_timeout_err, o_overrun} !== 3'b000) begin
      errors++; $display("FAIL reset_pulses: got %b want 000", {o_crc_err, o_timeout_err, o_overrun});
    end
  endtask

  task automatic test_basic;
    int c0, t0, v0;
    c0 = crc_cnt; t0 = tmo_cnt; v0 = ovr_cnt;
    i_ready = 1'b1;
    sb.push_back(model(8'h40, 8'h00, 8'h04, 8'h00));
    send_frame(8'h40, 8'h00, 8'h04, 8'h00, 8'h44);
    checks++;
    if (o_valid !== 1'b1 || o_xcord !== 10'h100 || o_ycord !== 10'h000 || o_phase !== 14'h1000) begin
      errors++; $display("FAIL basic_latency: got v=%b x=%h y=%h ph=%h want v=1 x=100 y=000 ph=1000",
                         o_valid, o_xcord, o_ycord, o_phase);
    end
    idle(1);
    checks++;
    if (o_valid !== 1'b0) begin errors++; $display("FAIL basic_fall: got %b want 0", o_valid); end
    checks++;
    if (crc_cnt != c0 || tmo_cnt != t0 || ovr_cnt != v0) begin
      errors++; $display("FAIL basic_no_err: got crc=%0d tmo=%0d ovr=%0d want %0d %0d %0d",
                         crc_cnt, tmo_cnt, ovr_cnt, c0, t0, v0);
    end
  endtask

  task automatic test_junk;
    sb.push_back(model(8'h40, 8'h00, 8'h04, 8'h00));
    send_byte(8'h13);
    send_byte(8'h77);
    send_frame(8'h40, 8'h00, 8'h04, 8'h00, 8'h44);
    idle(2);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL junk_drain: got %0d pending want 0", sb.size()); end
  endtask

  task automatic test_crc;
    int c0;
    c0 = crc_cnt;
    send_frame(8'h40, 8'h00, 8'h04, 8'h00, 8'h45);
    checks++;
    if (o_crc_err !== 1'b1 || o_valid !== 1'b0) begin
      errors++; $display("FAIL crc_pulse: got err=%b v=%b want err=1 v=0", o_crc_err, o_valid);
    end
    idle(3);
    checks++;
    if (crc_cnt != c0 + 1) begin errors++; $display("FAIL crc_count: got %0d want %0d", crc_cnt, c0 + 1); end
  endtask

  task automatic test_timeout;
    int t0;
    t0 = tmo_cnt;
    send_byte(8'hA5);
    send_byte(8'h40);
    send_byte(8'h00);
    idle(T + 1);
    checks++;
    if (o_timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_pulse: got %b want 1", o_timeout_err); end
    idle(3);
    checks++;
    if (tmo_cnt != t0 + 1) begin errors++; $display("FAIL tmo_count: got %0d want %0d", tmo_cnt, t0 + 1); end
    sb.push_back(model(8'h40, 8'h00, 8'h04, 8'h00));
    send_frame(8'h40, 8'h00, 8'h04, 8'h00, 8'h44);
    idle(2);
    // Byte lands exactly on the limit cycle: it must win.
    sb.push_back(model(8'h40, 8'h00, 8'h04, 8'h00));
    send_byte(8'hA5);
    send_byte(8'h40);
    send_byte(8'h00);
    idle(T);
    send_byte(8'h04);
    send_byte(8'h00);
    send_byte(8'h44);
    idle(2);
    checks++;
    if (tmo_cnt != t0 + 1 || sb.size() != 0) begin
      errors++; $display("FAIL tmo_boundary: got tmo=%0d pending=%0d want tmo=%0d pending=0",
                         tmo_cnt, sb.size(), t0 + 1);
    end
  endtask

  task automatic test_overrun;
    int v0;
    v0 = ovr_cnt;
    i_ready = 1'b0;
    sb.push_back(model(8'h40, 8'h00, 8'h04, 8'h00));
    send_frame(8'h40, 8'h00, 8'h04, 8'h00, 8'h44);
    send_frame(8'hFF, 8'hC0, 8'h0F, 8'hFF, 8'hCF);
    checks++;
    if (o_overrun !== 1'b1 || o_valid !== 1'b1 || o_xcord !== 10'h100) begin
      errors++; $display("FAIL ovr_hold: got ovr=%b v=%b x=%h want ovr=1 v=1 x=100", o_overrun, o_valid, o_xcord);
    end
    idle(2);
    i_ready = 1'b1;
    idle(1);
    checks++;
    if (o_valid !== 1'b0 || ovr_cnt != v0 + 1 || sb.size() != 0) begin
      errors++; $display("FAIL ovr_drain: got v=%b ovr=%0d pending=%0d want v=0 ovr=%0d pending=0",
                         o_valid, ovr_cnt, sb.size(), v0 + 1);
    end
  endtask

  task automatic test_back_to_back;
    int v0;
    v0 = ovr_cnt;
    i_ready = 1'b0;
    sb.push_back(model(8'h12, 8'h34, 8'h56, 8'h78));
    send_frame(8'h12, 8'h34, 8'h56, 8'h78, 8'h08);
    sb.push_back(model(8'hFF, 8'hC0, 8'h0F, 8'hFF));
    send_byte(8'hA5);
    send_byte(8'hFF);
    send_byte(8'hC0);
    send_byte(8'h0F);
    send_byte(8'hFF);
    i_ready = 1'b1;
    send_byte(8'hCF);
    checks++;
    if (o_valid !== 1'b1 || o_xcord !== 10'h3FF || o_phase !== 14'h3FFC) begin
      errors++; $display("FAIL b2b_load: got v=%b x=%h ph=%h want v=1 x=3ff ph=3ffc", o_valid, o_xcord, o_phase);
    end
    idle(1);
    checks++;
    if (o_valid !== 1'b0 || ovr_cnt != v0 || sb.size() != 0) begin
      errors++; $display("FAIL b2b_drain: got v=%b ovr=%0d pending=%0d want v=0 ovr=%0d pending=0",
                         o_valid, ovr_cnt, sb.size(), v0);
    end
  endtask

  task automatic test_reset_midframe;
    int c0, t0, v0;
    i_ready = 1'b0;
    send_frame(8'h40, 8'h00, 8'h04, 8'h00, 8'h44);
    send_byte(8'hA5);
    send_byte(8'h40);
    c0 = crc_cnt; t0 = tmo_cnt; v0 = ovr_cnt;
    i_reset = 1'b1;
    idle(1);
    checks++;
    if ({o_valid, o_xcord, o_ycord, o_phase, o_crc_err, o_timeout_err, o_overrun} !== 38'd0) begin
      errors++; $display("FAIL rst_mid_outputs: got v=%b x=%h y=%h ph=%h errs=%b want all 0",
                         o_valid, o_xcord, o_ycord, o_phase, {o_crc_err, o_timeout_err, o_overrun});
    end
    i_reset = 1'b0;
    i_ready = 1'b1;
    sb.push_back(model(8'h40, 8'h00, 8'h04, 8'h00));
    send_frame(8'h40, 8'h00, 8'h04, 8'h00, 8'h44);
    idle(3);
    checks++;
    if (sb.size() != 0 || crc_cnt != c0 || tmo_cnt != t0 || ovr_cnt != v0) begin
      errors++; $display("FAIL rst_mid_recover: got pending=%0d crc=%0d tmo=%0d ovr=%0d want 0 %0d %0d %0d",
                         sb.size(), crc_cnt, tmo_cnt, ovr_cnt, c0, t0, v0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1;
    test_reset;
    test_basic;
    test_junk;
    test_crc;
    test_timeout;
    test_overrun;
    test_back_to_back;
    test_reset_midframe;
    idle(5);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL final_drain: got %0d pending want 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cordic_cmd_deframer.md
Name: cordic_cmd_deframer

Overview:
- Upstream stage of the CORDIC engine. Consumes the raw byte stream from UART_RX (o_RX_DV/o_RX_Byte).
- Hunts for a sync byte, then collects a 4-byte payload and a checksum byte, with an inter-byte timeout.
- Delivers validated x/y/phase operands to the CORDIC input through a one-deep valid/ready holding register.
- Replaces ad-hoc byte counting, which loses alignment on any dropped or extra byte.

Parameters:
SYNC_BYTE, 8'hA5, frame start marker.
TIMEOUT_CYCLES, 100000, max clocks allowed between consecutive bytes inside a frame (~1 ms at 100 MHz).

Ports:
i_clk  input  1  system clock.
i_reset  input  1  synchronous, active-high reset.
i_rx_dv  input  1  one-cycle strobe: i_rx_byte is valid.
i_rx_byte  input  8  received byte.
i_ready  input  1  downstream accepts the operand when high in the same cycle as o_valid.
o_valid  output  1  operand held and available.
o_xcord  output  10  x operand.
o_ycord  output  10  y operand.
o_phase  output  14  phase operand.
o_crc_err  output  1  one-cycle pulse: checksum mismatch, frame discarded.
o_timeout_err  output  1  one-cycle pulse: inter-byte timeout, frame discarded.
o_overrun  output  1  one-cycle pulse: good frame discarded because the holding register was full.

Behaviour:
- Frame format: SYNC, P0, P1, P2, P3, CK. Payload word W = {P0,P1,P2,P3} (P0 = MSB).
- Checksum: CK = P0^P1^P2^P3.
- Field extraction: x = W[31:22], y = W[21:12], o_phase = {W[11:0], 2'b00}.
- Reset: state IDLE, byte index 0, timeout counter 0, o_valid 0, all error pulses 0, o_xcord/o_ycord/o_phase 0.
- IDLE: on i_rx_dv with byte == SYNC_BYTE, go to PAYLOAD with index 0. All other bytes are ignored silently.
- PAYLOAD: each i_rx_dv shifts the byte into W and increments the index. After the 4th byte, go to CHECK.
  - A SYNC_BYTE value here is treated as data.
- CHECK: on i_rx_dv, compare the byte to the running XOR.
  - Mismatch: pulse o_crc_err, go to IDLE. The failing byte is not re-examined as a sync byte.
  - Match with holding register empty, or emptying this cycle (o_valid & i_ready): load the fields, set o_valid the next cycle, go to IDLE.
  - Match with holding register full and not emptying: pulse o_overrun, keep the old operand, go to IDLE.
- Running XOR is computed incrementally; no second pass over the bytes.
- Timeout counter:
  - Cleared on every i_rx_dv and whenever the state is IDLE.
  - Increments each cycle in PAYLOAD/CHECK.
  - On reaching TIMEOUT_CYCLES: pulse o_timeout_err, go to IDLE.
  - If i_rx_dv arrives in the same cycle the counter hits the limit, the byte wins and no timeout fires.
  - Counter width is $clog2(TIMEOUT_CYCLES+1) and saturates; it never wraps.
- Handshake: o_valid stays high until the cycle with o_valid & i_ready, then falls the next cycle unless a new frame loads in that same cycle (back-to-back).
- o_xcord/o_ycord/o_phase are stable while o_valid is high.
- Latency: o_valid rises 1 cycle after the i_rx_dv carrying a correct CK.
- Error pulses are registered and last exactly 1 cycle. They are mutually exclusive by construction.
- Reset mid-frame: the partial frame is lost and the holding register is cleared. No error pulse is emitted.

Decomposition:
- Shared package cordic_pkg holds:
  - Constants: CORDIC_XY_W=10, CORDIC_PH_W=14, FRAME_PAYLOAD_BYTES=4.
  - Default SYNC_BYTE.
  - State encoding localparams IDLE/PAYLOAD/CHECK.
- One natural sub-module: cordic_operand_hold, the one-deep valid/ready register with overrun detect. It is reusable on the result side toward UART_TX.

Test Plan:
- Send A5 40 00 04 00 44 with i_ready=1 -> o_valid pulses 1 cycle after CK, with o_xcord=0x100, o_ycord=0x000, o_phase=0x1000; no error pulses.
- Send 13 77 A5 40 00 04 00 44 -> junk ignored; same operand as above.
- Send A5 40 00 04 00 45 -> o_crc_err exactly 1 cycle; o_valid stays 0.
- Send A5 40 00, then idle TIMEOUT_CYCLES clocks -> o_timeout_err once; then the full valid frame decodes correctly. Also place a byte on exactly the limit cycle -> no timeout.
- i_ready=0: two valid frames (second payload FF C0 0F FF, CK 0xCF) -> first held (x=0x100), o_overrun on the second frame's CK. Raise i_ready -> first consumed, o_valid falls.
- Assert i_reset after A5 40 -> all outputs 0. The next frame A5 40 00 04 00 44 decodes normally.
